// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus launch sequencer sitting directly upstream of uart_tx.
// Producers push bytes at clk rate. The sequencer pops one byte per UART frame and issues
// a one-cycle tx_data_valid pulse. It follows uart_tx's bps_en (tx_busy) so a byte is never
// launched into a frame that is still in progress.
//
// Ports:
//   clk, rst        system clock; synchronous active-high reset
//   wr_en, wr_data  write strobe and byte; accepted when !full
//   full, empty     FIFO holds DEPTH / 0 entries
//   level           current entry count, 0..DEPTH
//   overflow        1-cycle pulse: wr_en while full (byte dropped)
//   tx_err          1-cycle pulse: tx_busy never rose after a launch (byte dropped)
//   tx_busy         bps_en from uart_tx
//   tx_data_valid   1-cycle launch pulse to uart_tx
//   tx_data         byte to uart_tx; held stable until the next launch
module uart_tx_feeder #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned START_TO   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              tx_err,
  input  logic              tx_busy,
  output logic              tx_data_valid,
  output logic [7:0]        tx_data
);

  // One counter serves both the start timeout and the gap; sized for the larger of the two.
  localparam int unsigned CntMax = (GAP_CYCLES > START_TO) ? GAP_CYCLES : START_TO;
  localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitSt,
    StWaitDn,
    StGap
  } state_e;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              push, pop;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  assign full     = (count_q == (ADDR_W + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign overflow = overflow_q;
  assign tx_err   = err_q;
  assign tx_data_valid = valid_q;
  assign tx_data  = tx_data_q;

  // Fullness is judged on the registered count: a same-cycle pop does not make room.
  assign push = wr_en && !full;

  // Storage carries no reset; only the pointers and count define valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= wr_en && full;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A frame launched by someone else (or surviving our reset) must finish first.
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          valid_d   = 1'b1;
          state_d   = StLaunch;
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWaitSt;
      end
      StWaitSt: begin
        if (tx_busy) begin
          state_d = StWaitDn;
        end else if (cnt_q == CntW'(START_TO - 1)) begin
          // uart_tx never took the byte; report and move on without retrying.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitDn: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int BitCyc  = 4;
  localparam int StartTo = 15;
  localparam int GapCyc  = 20;

  logic       clk;
  logic       rst, wr_en, tx_busy;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_err, tx_data_valid;
  logic [4:0] level;
  logic [7:0] tx_data;

  logic       g_rst, g_wr_en, g_busy;
  logic [7:0] g_wr_data;
  logic       g_full, g_empty, g_overflow, g_tx_err, g_valid;
  logic [4:0] g_level;
  logic [7:0] g_tx_data;

  logic       model_en, model_busy, man_busy;
  logic       line_q[$];
  logic [7:0] cap_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  assign tx_busy = model_en ? model_busy : man_busy;

  uart_tx_feeder #(.DEPTH(16), .ADDR_W(4), .GAP_CYCLES(0), .START_TO(StartTo)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .tx_err(tx_err), .tx_busy(tx_busy),
    .tx_data_valid(tx_data_valid), .tx_data(tx_data)
  );

  uart_tx_feeder #(.DEPTH(16), .ADDR_W(4), .GAP_CYCLES(GapCyc), .START_TO(StartTo)) dut_gap (
    .clk(clk), .rst(g_rst), .wr_en(g_wr_en), .wr_data(g_wr_data), .full(g_full),
    .empty(g_empty), .level(g_level), .overflow(g_overflow), .tx_err(g_tx_err),
    .tx_busy(g_busy), .tx_data_valid(g_valid), .tx_data(g_tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Behavioural uart_tx: 10-bit frame (start, 8 data LSB first, stop), BitCyc clocks per bit.
  initial begin : uart_model
    logic [9:0] bits;
    model_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (model_en && tx_data_valid) begin
        cap_q.push_back(tx_data);
        model_busy = 1'b1;
        bits = {1'b1, tx_data, 1'b0};
        for (int b = 0; b < 10; b++) begin
          line_q.push_back(bits[b]);
          repeat (BitCyc) @(posedge clk);
        end
        #1 model_busy = 1'b0;
      end
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic [4:0] lvl;
    logic       vld;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin : main
    int n;
    int base;
    int bad;
    logic [9:0] got_bits;

    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; man_busy = 1'b0; model_en = 1'b0;
    g_rst = 1'b1; g_wr_en = 1'b0; g_wr_data = 8'h00; g_busy = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_err", tx_err, 0);
    check("rst_valid", tx_data_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    g_rst = 1'b0;

    // Table: foreign busy blocks launch, then hand-driven busy handshake, GAP_CYCLES=0
    vecs[0]  = '{1'b1, 8'h11, 1'b1, 5'd1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h22, 1'b1, 5'd2, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 8'h11};
    vecs[4]  = '{1'b1, 8'h33, 1'b0, 5'd2, 1'b0, 8'h11};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 8'h11};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 8'h11};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 8'h11};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 8'h22};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 8'h22};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 8'h22};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 8'h22};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 8'h33};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h33};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h33};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h33};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h33};
    for (int i = 0; i < 17; i++) begin
      wr_en = vecs[i].wr; wr_data = vecs[i].d; man_busy = vecs[i].busy;
      tick();
      check($sformatf("vec%0d_level", i), level, vecs[i].lvl);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].lvl == 0);
      check($sformatf("vec%0d_valid", i), tx_data_valid, vecs[i].vld);
      check($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].data);
      check($sformatf("vec%0d_overflow", i), overflow, 0);
    end
    wr_en = 1'b0; man_busy = 1'b0;

    // Test 1: single byte, latency and line pattern
    reset_dut();
    model_en = 1'b1;
    base = line_q.size();
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    check("t1_valid_edge_n", tx_data_valid, 0);
    check("t1_level_edge_n", level, 1);
    tick();
    check("t1_valid_edge_n1", tx_data_valid, 1);
    check("t1_tx_data", tx_data, 8'hA5);
    check("t1_level_popped", level, 0);
    tick();
    check("t1_valid_one_cycle", tx_data_valid, 0);
    n = 0;
    while (!(line_q.size() - base >= 10 && !model_busy) && n < 200) begin
      tick(); n++;
    end
    check("t1_frame_done", n < 200, 1);
    got_bits = '0;
    for (int b = 0; b < 10; b++) begin
      if (base + b < line_q.size()) got_bits[b] = line_q[base + b];
    end
    check("t1_line_bits", got_bits, 10'b1101001010);

    // Test 2: burst to full, overflow, ordered drain
    model_en = 1'b0; man_busy = 1'b1;
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    check("t2_full", full, 1);
    check("t2_level16", level, 16);
    wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    check("t2_overflow", overflow, 1);
    check("t2_level_after_ovf", level, 16);
    tick();
    check("t2_overflow_pulse", overflow, 0);
    base = cap_q.size();
    model_en = 1'b1;
    n = 0;
    while (!(cap_q.size() - base >= 16 && !model_busy) && n < 2000) begin
      tick(); n++;
    end
    check("t2_drain_done", n < 2000, 1);
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      if (base + i < cap_q.size()) check($sformatf("t2_order%0d", i), cap_q[base + i], i);
      else check($sformatf("t2_order%0d", i), 32'hFFFF, i);
    end
    check("t2_empty_end", empty, 1);
    check("t2_frames_sent", cap_q.size() - base, 16);

    // Test 3: write while launching from a full FIFO
    model_en = 1'b0; man_busy = 1'b1;
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      tick();
    end
    man_busy = 1'b0; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    check("t3_overflow", overflow, 1);
    check("t3_level15", level, 15);
    check("t3_valid", tx_data_valid, 1);
    check("t3_head", tx_data, 8'h40);

    // Test 4: start timeout, then next byte launches normally
    man_busy = 1'b1;
    reset_dut();
    wr_en = 1'b1; wr_data = 8'h5A; tick();
    wr_data = 8'hC3; tick();
    wr_en = 1'b0; man_busy = 1'b0;
    tick();
    check("t4_launch1", tx_data_valid, 1);
    check("t4_data1", tx_data, 8'h5A);
    n = 0; bad = 0;
    do begin
      tick(); n++;
      if (tx_data_valid) bad++;
    end while (!tx_err && n < 40);
    check("t4_err_delay", n, StartTo + 1);
    check("t4_no_valid_while_waiting", bad, 0);
    tick();
    check("t4_err_pulse", tx_err, 0);
    check("t4_launch2", tx_data_valid, 1);
    check("t4_data2", tx_data, 8'hC3);

    // Test 6: reset during WAIT_DN with 5 bytes queued
    man_busy = 1'b0;
    reset_dut();
    model_en = 1'b1;
    base = cap_q.size();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
    tick(); tick();
    check("t6_level5", level, 5);
    check("t6_busy_in_frame", model_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_level0", level, 0);
    check("t6_empty", empty, 1);
    check("t6_full", full, 0);
    check("t6_valid", tx_data_valid, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_data_valid !== 1'b0) bad++;
    end
    check("t6_no_launch_after_rst", bad, 0);
    check("t6_frames_sent", cap_q.size() - base, 1);

    // Test 5: GAP_CYCLES=20 instance
    g_busy = 1'b1;
    g_wr_en = 1'b1; g_wr_data = 8'h81; tick();
    g_wr_data = 8'h7E; tick();
    g_wr_en = 1'b0; g_busy = 1'b0;
    tick();
    check("t5_launch1", g_valid, 1);
    check("t5_data1", g_tx_data, 8'h81);
    tick();
    g_busy = 1'b1;
    repeat (3) tick();
    g_busy = 1'b0;
    tick();
    n = 0;
    while (!g_valid && n < 60) begin
      tick(); n++;
    end
    check("t5_gap_delay", n, GapCyc + 1);
    check("t5_data2", g_tx_data, 8'h7E);
    check("t5_level0", g_level, 0);
    check("t5_empty", g_empty, 1);
    check("t5_flags", {g_full, g_overflow, g_tx_err}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
